instruction_issuer: RTL and testbench

INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

---
 rtl/instruction_issuer_pkg.sv | 32 +++
 rtl/issue_fifo.sv | 54 +++++
 rtl/instruction_issuer.sv | 116 +++++++++++
 tb/tb_instruction_issuer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_issuer_pkg.sv
// Shared definitions for the instruction issuer: field layout, instruction types,
// stall opcodes and the issue FSM state encoding.
package instruction_issuer_pkg;

    localparam int INSTR_W = 32;
    localparam int TYPE_HI = 31;
    localparam int TYPE_LO = 30;
    localparam int OP_HI   = 29;
    localparam int OP_LO   = 25;

    localparam logic [1:0] TYPE_MEM  = 2'b00;
    localparam logic [1:0] TYPE_DATA = 2'b01;
    localparam logic [1:0] TYPE_CTRL = 2'b10;
    localparam logic [1:0] TYPE_VEC  = 2'b11;

    localparam logic [4:0] OP_STALL_STD = 5'b00101;
    localparam logic [4:0] OP_STALL_RD  = 5'b00110;
    localparam logic [4:0] OP_STALL_WR  = 5'b00111;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        STALL_RD = 2'd1,
        STALL_WR = 2'd2,
        STALL_BR = 2'd3
    } state_t;

    // Inserted stall words are DATA-type with an all-zero operand field.
    function automatic logic [INSTR_W-1:0] stall_word(input logic [4:0] op);
        return {TYPE_DATA, op, 25'b0};
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Two-entry FIFO buffering fetched words ahead of the issue FSM.
module issue_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    // Flush wins over both a same-cycle push and pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_issuer.sv
// Issues buffered instruction words to decode, inserting fixed-length stall
// sequences after vector loads, vector stores and control instructions.
module instruction_issuer
    import instruction_issuer_pkg::*;
#(
    parameter int RD_STALLS = 2,
    parameter int WR_STALLS = 2,
    parameter int BR_STALLS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic               stall_active
);

    state_t             state, state_n;
    logic [2:0]         cnt, cnt_n;
    logic               ready_q;
    logic               push, pop;
    logic               full, empty;
    logic [INSTR_W-1:0] head;
    logic               is_load, is_store, is_ctrl;

    // Held low through reset and released on the first edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else     ready_q <= 1'b1;
    end

    assign in_ready = ready_q && !full;
    assign push     = in_valid && in_ready;

    issue_fifo #(.WIDTH(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (in_instr),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign is_load  = (head[TYPE_HI:TYPE_LO] == TYPE_MEM) && (head[OP_HI -: 2] == 2'b10);
    assign is_store = (head[TYPE_HI:TYPE_LO] == TYPE_MEM) && (head[OP_HI -: 2] == 2'b11);
    assign is_ctrl  = (head[TYPE_HI:TYPE_LO] == TYPE_CTRL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ISSUE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pop          = 1'b0;
        out_valid    = 1'b0;
        stall_active = 1'b0;
        out_instr    = stall_word(OP_STALL_STD);
        case (state)
            ISSUE: begin
                if (!empty) begin
                    out_valid = 1'b1;
                    out_instr = head;
                    pop       = out_ready;
                    if (out_ready) begin
                        if (is_load && RD_STALLS > 0) begin
                            state_n = STALL_RD;
                            cnt_n   = 3'(RD_STALLS);
                        end else if (is_store && WR_STALLS > 0) begin
                            state_n = STALL_WR;
                            cnt_n   = 3'(WR_STALLS);
                        end else if (is_ctrl && BR_STALLS > 0) begin
                            state_n = STALL_BR;
                            cnt_n   = 3'(BR_STALLS);
                        end
                    end
                end
            end
            default: begin
                out_valid    = 1'b1;
                stall_active = 1'b1;
                case (state)
                    STALL_RD: out_instr = stall_word(OP_STALL_RD);
                    STALL_WR: out_instr = stall_word(OP_STALL_WR);
                    default:  out_instr = stall_word(OP_STALL_STD);
                endcase
                // The stall word in flight counts only once decode takes it.
                if (out_ready) begin
                    cnt_n = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_n = ISSUE;
                        cnt_n   = 3'd0;
                    end
                end
            end
        endcase
        if (flush) begin
            state_n = ISSUE;
            cnt_n   = 3'd0;
        end
    end

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer: plain issue, stall insertion,
// backpressure, flush and asynchronous reset.
module tb_instruction_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic        flush;
    logic        stall_active;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] W_STD = 32'h4A00_0000;
    localparam logic [31:0] W_RD  = 32'h4C00_0000;
    localparam logic [31:0] W_WR  = 32'h4E00_0000;

    instruction_issuer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .flush        (flush),
        .stall_active (stall_active)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [4:0] op, input logic [24:0] opnd);
        return {t, op, opnd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        #2;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (stall_active !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", stall_active); end
        n_cmp++; if (out_instr !== W_STD) begin n_bad++; $display("FAIL rst_out_instr got=%h exp=%h", out_instr, W_STD); end
        step(); step();
        rst = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_issue();
        logic [31:0] a, b;
        a = mk(2'b01, 5'b00000, 25'h0123456);
        b = mk(2'b01, 5'b00000, 25'h1ABCDEF);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = a;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== a) begin n_bad++; $display("FAIL issue_a got=%b/%h exp=1/%h", out_valid, out_instr, a); end
        n_cmp++; if (stall_active !== 1'b0) begin n_bad++; $display("FAIL issue_a_stall got=%b exp=0", stall_active); end
        in_instr = b;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== b) begin n_bad++; $display("FAIL issue_b got=%b/%h exp=1/%h", out_valid, out_instr, b); end
        n_cmp++; if (stall_active !== 1'b0) begin n_bad++; $display("FAIL issue_b_stall got=%b exp=0", stall_active); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || out_instr !== W_STD) begin n_bad++; $display("FAIL issue_idle got=%b/%h exp=0/%h", out_valid, out_instr, W_STD); end
    endtask

    task automatic test_vec_load();
        logic [31:0] ld, c;
        ld = mk(2'b00, 5'b10000, 25'h0000ABC);
        c  = mk(2'b01, 5'b00000, 25'h0000042);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = ld;
        step();
        n_cmp++; if (out_instr !== ld) begin n_bad++; $display("FAIL ld_issue got=%h exp=%h", out_instr, ld); end
        in_instr = c;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== W_RD || stall_active !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL ld_stall1 got=%h/%b exp=%h/1", out_instr, stall_active, W_RD); end
        step();
        n_cmp++; if (out_instr !== W_RD || stall_active !== 1'b1) begin n_bad++; $display("FAIL ld_stall2 got=%h/%b exp=%h/1", out_instr, stall_active, W_RD); end
        step();
        n_cmp++; if (out_instr !== c || stall_active !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL ld_after got=%h/%b exp=%h/0", out_instr, stall_active, c); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ld_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_branch();
        logic [31:0] br;
        int stalls;
        br = mk(2'b10, 5'b00000, 25'h0000100);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = br;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== br) begin n_bad++; $display("FAIL br_issue got=%h exp=%h", out_instr, br); end
        step();
        out_ready = 1'b0;
        n_cmp++; if (out_instr !== W_STD || stall_active !== 1'b1) begin n_bad++; $display("FAIL br_stall got=%h/%b exp=%h/1", out_instr, stall_active, W_STD); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (out_instr !== W_STD || out_valid !== 1'b1 || stall_active !== 1'b1) begin n_bad++; $display("FAIL br_hold%0d got=%h/%b/%b exp=%h/1/1", i, out_instr, out_valid, stall_active, W_STD); end
        end
        out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (!stall_active) break;
            stalls++;
            step();
        end
        n_cmp++; if (stalls != 3) begin n_bad++; $display("FAIL br_count got=%0d exp=3", stalls); end
        n_cmp++; if (out_valid !== 1'b0 || stall_active !== 1'b0) begin n_bad++; $display("FAIL br_done got=%b/%b exp=0/0", out_valid, stall_active); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2, w3;
        w1 = mk(2'b01, 5'b00001, 25'h0000011);
        w2 = mk(2'b01, 5'b00010, 25'h0000022);
        w3 = mk(2'b11, 5'b00011, 25'h0000033);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = w1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        in_instr = w2;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        in_instr = w3;
        step();
        n_cmp++; if (in_ready !== 1'b0 || out_instr !== w1) begin n_bad++; $display("FAIL bp_hold got=%b/%h exp=0/%h", in_ready, out_instr, w1); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_instr !== w2) begin n_bad++; $display("FAIL bp_pop1 got=%b/%h exp=1/%h", in_ready, out_instr, w2); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== w3 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_w3 got=%b/%h exp=1/%h", out_valid, out_instr, w3); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] st, d1, d2;
        st = mk(2'b00, 5'b11000, 25'h0000777);
        d1 = mk(2'b01, 5'b00001, 25'h0000001);
        d2 = mk(2'b01, 5'b00001, 25'h0000002);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = st;
        step();
        in_instr = d1;
        step();
        out_ready = 1'b0;
        in_instr = d2;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== W_WR || stall_active !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL fl_pre got=%h/%b/%b exp=%h/1/0", out_instr, stall_active, in_ready, W_WR); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || stall_active !== 1'b0 || out_instr !== W_STD) begin n_bad++; $display("FAIL fl_idle got=%b/%b/%h exp=0/0/%h", out_valid, stall_active, out_instr, W_STD); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fl_empty got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1; in_instr = d1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fl_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_rst_async();
        logic [31:0] ld;
        ld = mk(2'b00, 5'b10101, 25'h0000555);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = ld;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (stall_active !== 1'b1 || out_instr !== W_RD) begin n_bad++; $display("FAIL ar_pre got=%b/%h exp=1/%h", stall_active, out_instr, W_RD); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || stall_active !== 1'b0 || in_ready !== 1'b0 || out_instr !== W_STD) begin
            n_bad++; $display("FAIL ar_now got=%b/%b/%b/%h exp=0/0/0/%h", out_valid, stall_active, in_ready, out_instr, W_STD);
        end
        rst = 1'b0;
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_after got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_vec_load();
        test_branch();
        test_back_to_back();
        test_flush();
        test_rst_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
